uart_rx_fifo: RTL and testbench

- Receive-side FIFO of the UART core. It buffers 11-bit receiver words: {data[7:0], break, parity_error, framing_error}.
- The receiver's push pulse writes words in; the register interface (LSR/RBR read path) pops them out.
- Outputs the fill level, an aggregate line-error flag for LSR[7], and a sticky overrun flag.

---
 rtl/uart_rx_fifo.sv | 147 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side FIFO of the UART core. Buffers receiver words laid out as
//   {data[7:0], break, parity_error, framing_error}; the receiver pushes,
//   the register interface (LSR/RBR read path) pops.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   data_in    word to write
//   push       single-cycle write strobe
//   pop        single-cycle read strobe
//   data_out   head entry (show-ahead), 0 when empty
//   count      number of stored words (0..FIFO_DEPTH)
//   error_bit  some stored word has a nonzero error field [2:0]
//   overrun    sticky: a push was dropped because the FIFO was full
//
// Build option:
//   UART_RFIFO_ERROR_BIT_EN  when defined, builds the error-field shadow
//                            storage and error_bit logic; otherwise
//                            error_bit is tied to 0.
module uart_rx_fifo #(
    parameter int FIFO_WIDTH     = 11,
    parameter int FIFO_DEPTH     = 16,
    parameter int FIFO_POINTER_W = 4,
    parameter int FIFO_COUNTER_W = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [FIFO_WIDTH-1:0]     data_in,
    input  logic                      push,
    input  logic                      pop,
    output logic [FIFO_WIDTH-1:0]     data_out,
    output logic [FIFO_COUNTER_W-1:0] count,
    output logic                      error_bit,
    output logic                      overrun
);

    localparam logic [FIFO_COUNTER_W-1:0] FULL_COUNT = FIFO_COUNTER_W'(FIFO_DEPTH);
    localparam logic [FIFO_COUNTER_W-1:0] CNT_ONE    = FIFO_COUNTER_W'(1);
    localparam logic [FIFO_POINTER_W-1:0] PTR_ONE    = FIFO_POINTER_W'(1);

    logic [FIFO_WIDTH-1:0]     mem_q [FIFO_DEPTH];
    logic [FIFO_WIDTH-1:0]     mem_d [FIFO_DEPTH];
    logic [FIFO_POINTER_W-1:0] top_q, top_d;
    logic [FIFO_POINTER_W-1:0] bottom_q, bottom_d;
    logic [FIFO_COUNTER_W-1:0] count_q, count_d;
    logic                      overrun_q, overrun_d;
    logic                      full;
    logic                      wr_en;
    logic                      rd_en;

    always_comb begin
        full  = (count_q == FULL_COUNT);
        rd_en = pop && (count_q != '0);
        // A pop on a non-empty FIFO frees the slot, so push succeeds even when full.
        wr_en = push && (!full || rd_en);

        top_d    = wr_en ? top_q + PTR_ONE : top_q;
        bottom_d = rd_en ? bottom_q + PTR_ONE : bottom_q;

        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CNT_ONE;
        end

        overrun_d = overrun_q;
        if (rd_en) begin
            overrun_d = 1'b0;
        end else if (push && full) begin
            overrun_d = 1'b1;
        end

        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en) begin
            mem_d[top_q] = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            top_q     <= '0;
            bottom_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            top_q     <= top_d;
            bottom_q  <= bottom_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

`ifdef UART_RFIFO_ERROR_BIT_EN
    logic [2:0] err_q [FIFO_DEPTH];
    logic [2:0] err_d [FIFO_DEPTH];
    logic       error_bit_q, error_bit_d;

    // Popped slots are cleared, so an OR over the whole shadow equals an OR
    // over valid entries. Clear before write: when full with push+pop,
    // top == bottom and the new word must win.
    always_comb begin
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            err_d[i] = err_q[i];
        end
        if (rd_en) begin
            err_d[bottom_q] = '0;
        end
        if (wr_en) begin
            err_d[top_q] = data_in[2:0];
        end
        error_bit_d = 1'b0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            error_bit_d = error_bit_d | (|err_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                err_q[i] <= '0;
            end
            error_bit_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                err_q[i] <= err_d[i];
            end
            error_bit_q <= error_bit_d;
        end
    end

    assign error_bit = error_bit_q;
`else
    assign error_bit = 1'b0;
`endif

    assign data_out = (count_q != '0) ? mem_q[bottom_q] : '0;
    assign count    = count_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic        clk;
    logic        rst_n;
    logic [10:0] data_in;
    logic        push;
    logic        pop;
    logic [10:0] data_out;
    logic [4:0]  count;
    logic        error_bit;
    logic        overrun;

    uart_rx_fifo #(
        .FIFO_WIDTH     (11),
        .FIFO_DEPTH     (16),
        .FIFO_POINTER_W (4),
        .FIFO_COUNTER_W (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .push      (push),
        .pop       (pop),
        .data_out  (data_out),
        .count     (count),
        .error_bit (error_bit),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: words expected to come out, in order.
    logic [10:0] sb[$];
    logic        m_ovr;
    int          n_total;
    int          n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic exp_err();
        logic e;
        e = 1'b0;
`ifdef UART_RFIFO_ERROR_BIT_EN
        foreach (sb[i]) e = e | (|sb[i][2:0]);
`endif
        return e;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'(sb.size()));
        check({tag, "_data_out"}, 32'(data_out), (sb.size() > 0) ? 32'(sb[0]) : 32'h0);
        check({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
        check({tag, "_error_bit"}, 32'(error_bit), 32'(exp_err()));
    endtask

    // One clock cycle of stimulus, driven at the falling edge.
    task automatic step(input string tag, input logic p, input logic q, input logic [10:0] d);
        logic [10:0] head_obs;
        logic        full;
        logic        rd;
        logic        wr;
        logic [10:0] exp_word;
        head_obs = data_out;
        push     = p;
        pop      = q;
        data_in  = d;
        @(posedge clk);
        #1;
        full = (sb.size() == 16);
        rd   = q && (sb.size() > 0);
        wr   = p && (!full || rd);
        if (rd) begin
            exp_word = sb.pop_front();
            check({tag, "_popped"}, 32'(head_obs), 32'(exp_word));
            m_ovr = 1'b0;
        end else if (p && full) begin
            m_ovr = 1'b1;
        end
        if (wr) sb.push_back(d);
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        check_state(tag);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag, input logic p);
        rst_n   = 1'b0;
        push    = p;
        data_in = 11'h155;
        @(posedge clk);
        #1;
        sb.delete();
        m_ovr   = 1'b0;
        push    = 1'b0;
        data_in = '0;
        rst_n   = 1'b1;
        check_state(tag);
        @(negedge clk);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        m_ovr   = 1'b0;
        rst_n   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        @(negedge clk);
        do_reset("reset", 1'b0);
        step("idle", 1'b0, 1'b0, 11'h0);
        step("pop_empty", 1'b0, 1'b1, 11'h0);

        // Clean words
        step("push_a", 1'b1, 1'b0, 11'h2A8);
        step("push_b", 1'b1, 1'b0, 11'h550);
        step("push_c", 1'b1, 1'b0, 11'h7F8);
        check("head_after3", 32'(data_out), 32'h2A8);
        step("pop_a", 1'b0, 1'b1, 11'h0);
        check("head_after_pop", 32'(data_out), 32'h550);
        step("pop_b", 1'b0, 1'b1, 11'h0);
        step("pop_c", 1'b0, 1'b1, 11'h0);

        // Framing-error word between clean words
        step("err_push0", 1'b1, 1'b0, 11'h208);
        step("err_push1", 1'b1, 1'b0, 11'h101);
        step("err_push2", 1'b1, 1'b0, 11'h310);
        step("err_pop0", 1'b0, 1'b1, 11'h0);
        step("err_pop1", 1'b0, 1'b1, 11'h0);
        step("err_pop2", 1'b0, 1'b1, 11'h0);

        // Push+pop on empty acts as push only
        step("pp_empty", 1'b1, 1'b1, 11'h0C3);
        step("pp_empty_drain", 1'b0, 1'b1, 11'h0);

        // Fill, overflow, drain (pointers wrap past 15)
        for (int i = 0; i < 16; i++) step("fill", 1'b1, 1'b0, 11'(i * 37 + 5));
        step("overflow", 1'b1, 1'b0, 11'h3FF);
        for (int i = 0; i < 16; i++) step("drain", 1'b0, 1'b1, 11'h0);

        // Full with push+pop together
        for (int i = 0; i < 16; i++) step("refill", 1'b1, 1'b0, 11'(11'h400 | 11'(i * 8 + (i % 3))));
        step("overflow2", 1'b1, 1'b0, 11'h3FF);
        step("pp_full", 1'b1, 1'b1, 11'h0AA);
        for (int i = 0; i < 16; i++) step("drain2", 1'b0, 1'b1, 11'h0);

        // Reset overrides push with count=5
        for (int i = 0; i < 5; i++) step("pre_reset", 1'b1, 1'b0, 11'(11'h201 + i));
        step("pre_reset_ovr_chk", 1'b0, 1'b0, 11'h0);
        do_reset("reset_push", 1'b1);
        step("post_reset_idle", 1'b0, 1'b0, 11'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
